// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock FIFO.
//   fifo_mode_e  : read-port mode (registered read or first-word-fall-through)
//   level_width  : bit width needed for a 0..2^addr_w fill count
package sync_fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // A count that can reach 2^addr_w (inclusive) needs one bit more than
  // the address; clamp to at least 1 so a zero-width address still works.
  function automatic int level_width(input int addr_w);
    return (addr_w < 0) ? 1 : addr_w + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage for sync_fifo.
//   clk   : sole clock
//   we    : write enable, wdata stored at waddr on posedge
//   waddr : write address
//   wdata : write word
//   re    : read enable (registered-read mode only)
//   raddr : read address
//   rdata : read word; registered (REG_READ=1, updates only when re) or
//           combinational from raddr (REG_READ=0)
// The memory is never reset; the owner discards stale contents logically.
module sync_fifo_ram #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter bit REG_READ   = 1'b1
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  if (REG_READ) begin : g_reg_read
    logic [DATA_WIDTH-1:0] rdata_q;

    // Holds the last word read when re is low.
    always_ff @(posedge clk) begin
      if (re) begin
        rdata_q <= mem[raddr];
      end
    end

    assign rdata = rdata_q;
  end else begin : g_comb_read
    // The head word is always presented, so the read strobe is not needed.
    logic unused_re;
    assign unused_re = re;
    assign rdata     = mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill level, almost-full/almost-empty thresholds,
// selectable standard or first-word-fall-through read, and sticky
// overflow/underflow flags.
//   clk, rst      : clock, synchronous active-high reset
//   wr_data/wr_en : write port; full, almost_full status
//   rd_en         : pop request; rd_data/rd_valid read word and qualifier
//   empty, almost_empty, level : occupancy status (level is 0..DEPTH)
//   clr_err       : clears overflow/underflow (a same-cycle set wins)
//   overflow      : sticky, write attempted while full
//   underflow     : sticky, read attempted while empty
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 14,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  input  logic                  clr_err,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam int         LW    = level_width(ADDR_WIDTH);
  localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo: AF_THRESH=%0d outside 1..%0d", AF_THRESH, DEPTH);
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH=%0d outside 0..%0d", AE_THRESH, DEPTH - 1);
  end

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [LW-1:0]         level_q;
  logic [LW-1:0]         level_next;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Accept decisions use the registered full/empty, so a full FIFO still
  // takes a read (and rejects the write) in the same cycle, and vice versa.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_comb begin
    level_next = level_q;
    if (wr_acc && !rd_acc) begin
      level_next = level_q + LW'(1);
    end else if (rd_acc && !wr_acc) begin
      level_next = level_q - LW'(1);
    end
  end

  // Pointers, level and status flags; flags are registered from level_next
  // rather than derived from pointer compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level_q      <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      almost_empty <= 1'b1;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      level_q      <= level_next;
      empty        <= (level_next == '0);
      full         <= (level_next == DEPTH_L);
      almost_empty <= (level_next <= AE_L);
      almost_full  <= (level_next >= AF_L);
      // A set event in the same cycle as clr_err takes priority.
      overflow     <= (wr_en & full)  | (overflow  & ~clr_err);
      underflow    <= (rd_en & empty) | (underflow & ~clr_err);
    end
  end

  assign level = level_q;

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .REG_READ   (MODE == FIFO_STD)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  if (MODE == FIFO_STD) begin : g_std_read
    logic rd_valid_q;
    logic rd_seen_q;

    // The storage itself is not reset; rd_seen_q forces rd_data to zero
    // from reset until the first popped word arrives.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_valid_q <= 1'b0;
        rd_seen_q  <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) begin
          rd_seen_q <= 1'b1;
        end
      end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_seen_q ? ram_rdata : '0;
  end else begin : g_fwft_read
    // Head word is visible whenever something is stored.
    assign rd_valid = ~empty;
    assign rd_data  = ram_rdata;
  end

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance (defaults)
  logic        rst = 1'b1;
  logic [15:0] wr_data = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic        full, almost_full, empty, almost_empty, rd_valid;
  logic        overflow, underflow;
  logic [15:0] rd_data;
  logic [4:0]  level;

  // FWFT instance
  logic        f_rst = 1'b1;
  logic [15:0] f_wr_data = '0;
  logic        f_wr_en = 1'b0;
  logic        f_rd_en = 1'b0;
  logic        f_clr_err = 1'b0;
  logic        f_full, f_almost_full, f_empty, f_almost_empty, f_rd_valid;
  logic        f_overflow, f_underflow;
  logic [15:0] f_rd_data;
  logic [4:0]  f_level;

  int checks = 0;
  int errors = 0;

  sync_fifo dut_std (
    .clk          (clk),
    .rst          (rst),
    .wr_data      (wr_data),
    .wr_en        (wr_en),
    .full         (full),
    .almost_full  (almost_full),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .almost_empty (almost_empty),
    .level        (level),
    .clr_err      (clr_err),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  sync_fifo #(.FWFT(1)) dut_fwft (
    .clk          (clk),
    .rst          (f_rst),
    .wr_data      (f_wr_data),
    .wr_en        (f_wr_en),
    .full         (f_full),
    .almost_full  (f_almost_full),
    .rd_en        (f_rd_en),
    .rd_data      (f_rd_data),
    .rd_valid     (f_rd_valid),
    .empty        (f_empty),
    .almost_empty (f_almost_empty),
    .level        (f_level),
    .clr_err      (f_clr_err),
    .overflow     (f_overflow),
    .underflow    (f_underflow)
  );

  // Advance one clock and settle away from the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; f_rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({empty, full, almost_empty, almost_full} !== 4'b1010) begin
      errors++; $display("FAIL reset_flags got %b expected 1010", {empty, full, almost_empty, almost_full});
    end
    checks++;
    if (level !== 5'd0) begin
      errors++; $display("FAIL reset_level got %0d expected 0", level);
    end
    checks++;
    if ({rd_valid, overflow, underflow} !== 3'b000 || rd_data !== 16'h0) begin
      errors++; $display("FAIL reset_out got v=%b o=%b u=%b d=%h expected 0", rd_valid, overflow, underflow, rd_data);
    end
    checks++;
    if ({f_empty, f_rd_valid, f_level} !== {1'b1, 1'b0, 5'd0}) begin
      errors++; $display("FAIL reset_fwft got e=%b v=%b l=%0d expected e=1 v=0 l=0", f_empty, f_rd_valid, f_level);
    end
    rst = 1'b0; f_rst = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      tick();
      checks++;
      if (level !== 5'(i + 1) || almost_full !== (i + 1 >= 14) || full !== (i + 1 == 16)) begin
        errors++;
        $display("FAIL fill_%0d got l=%0d af=%b f=%b expected l=%0d af=%b f=%b", i, level, almost_full, full, i + 1, (i + 1 >= 14), (i + 1 == 16));
      end
    end
    wr_data = 16'd99;
    tick();
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16 || full !== 1'b1) begin
      errors++; $display("FAIL overflow_17th got o=%b l=%0d f=%b expected o=1 l=16 f=1", overflow, level, full);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== 16'(i)) begin
        errors++; $display("FAIL drain_%0d got v=%b d=%0d expected v=1 d=%0d", i, rd_valid, rd_data, i);
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 16'd15 || empty !== 1'b1 || underflow !== 1'b0) begin
      errors++; $display("FAIL drain_end got v=%b d=%0d e=%b u=%b expected v=0 d=15 e=1 u=0", rd_valid, rd_data, empty, underflow);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL clr_overflow got %b expected 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; wr_data = 16'(i);
      tick();
    end
    for (int k = 0; k < 40; k++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'(100 + k);
      tick();
      exp_d = (k < 8) ? 16'(k) : 16'(92 + k);
      checks++;
      if (level !== 5'd8 || rd_valid !== 1'b1 || rd_data !== exp_d) begin
        errors++; $display("FAIL b2b_%0d got l=%0d v=%b d=%0d expected l=8 v=1 d=%0d", k, level, rd_valid, rd_data, exp_d);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      checks++;
      if (rd_data !== 16'(132 + i)) begin
        errors++; $display("FAIL b2b_tail_%0d got %0d expected %0d", i, rd_data, 132 + i);
      end
    end
    rd_en = 1'b0;
    tick();
    checks++;
    if (empty !== 1'b1 || level !== 5'd0) begin
      errors++; $display("FAIL b2b_empty got e=%b l=%0d expected e=1 l=0", empty, level);
    end
  endtask

  task automatic test_boundaries();
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hA5A5;
    tick();
    wr_en = 1'b0;
    checks++;
    if (underflow !== 1'b1 || level !== 5'd1 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL empty_both got u=%b l=%0d v=%b expected u=1 l=1 v=0", underflow, level, rd_valid);
    end
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 16'hA5A5 || rd_valid !== 1'b1 || level !== 5'd0) begin
      errors++; $display("FAIL empty_both_read got d=%h v=%b l=%0d expected d=a5a5 v=1 l=0", rd_data, rd_valid, level);
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (underflow !== 1'b0) begin
      errors++; $display("FAIL clr_underflow got %b expected 0", underflow);
    end
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 16'(200 + i);
      tick();
    end
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    rd_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd15 || rd_data !== 16'd200 || full !== 1'b0) begin
      errors++; $display("FAIL full_both got o=%b l=%0d d=%0d f=%b expected o=1 l=15 d=200 f=0", overflow, level, rd_data, full);
    end
  endtask

  task automatic test_err_clear();
    wr_en = 1'b1; wr_data = 16'h1234;
    tick();
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1) begin
      errors++; $display("FAIL refill got f=%b o=%b expected f=1 o=1", full, overflow);
    end
    clr_err = 1'b1;
    tick();
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || level !== 5'd16) begin
      errors++; $display("FAIL clr_vs_set got o=%b l=%0d expected o=1 l=16", overflow, level);
    end
    tick();
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL clr_after got %b expected 0", overflow);
    end
  endtask

  task automatic test_reset_midstream();
    rst = 1'b1;
    tick();
    rst = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_data = 16'(300 + i);
      tick();
    end
    checks++;
    if (level !== 5'd9 || underflow !== 1'b1) begin
      errors++; $display("FAIL pre_reset got l=%0d u=%b expected l=9 u=1", level, underflow);
    end
    rst = 1'b1; rd_en = 1'b1; wr_en = 1'b1;
    tick();
    rst = 1'b0; rd_en = 1'b0;
    checks++;
    if (level !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0 || rd_data !== 16'h0) begin
      errors++; $display("FAIL mid_reset got l=%0d e=%b v=%b o=%b u=%b d=%h expected l=0 e=1 v=0 o=0 u=0 d=0", level, empty, rd_valid, overflow, underflow, rd_data);
    end
    wr_en = 1'b1; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0;
    checks++;
    if (level !== 5'd1 || empty !== 1'b0) begin
      errors++; $display("FAIL post_reset_wr got l=%0d e=%b expected l=1 e=0", level, empty);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (rd_data !== 16'hBEEF || rd_valid !== 1'b1) begin
      errors++; $display("FAIL post_reset_rd got d=%h v=%b expected d=beef v=1", rd_data, rd_valid);
    end
  endtask

  task automatic test_fwft();
    f_wr_en = 1'b1; f_wr_data = 16'h0001;
    tick();
    f_wr_en = 1'b0;
    checks++;
    if (f_empty !== 1'b0 || f_rd_valid !== 1'b1 || f_rd_data !== 16'h0001) begin
      errors++; $display("FAIL fwft_first got e=%b v=%b d=%h expected e=0 v=1 d=0001", f_empty, f_rd_valid, f_rd_data);
    end
    f_wr_en = 1'b1; f_wr_data = 16'h0002;
    tick();
    f_wr_en = 1'b0;
    checks++;
    if (f_rd_data !== 16'h0001 || f_level !== 5'd2) begin
      errors++; $display("FAIL fwft_hold got d=%h l=%0d expected d=0001 l=2", f_rd_data, f_level);
    end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    checks++;
    if (f_rd_data !== 16'h0002 || f_rd_valid !== 1'b1 || f_level !== 5'd1) begin
      errors++; $display("FAIL fwft_pop got d=%h v=%b l=%0d expected d=0002 v=1 l=1", f_rd_data, f_rd_valid, f_level);
    end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    checks++;
    if (f_rd_valid !== 1'b0 || f_empty !== 1'b1 || f_underflow !== 1'b0) begin
      errors++; $display("FAIL fwft_empty got v=%b e=%b u=%b expected v=0 e=1 u=0", f_rd_valid, f_empty, f_underflow);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_boundaries();
    test_err_clear();
    test_reset_midstream();
    test_fwft();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
